// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART blocks (uart_rx, uart_tx, uart_loader).
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int FRAME_HDR_BYTES = 4;
  localparam int WORD_BYTES      = 4;

  typedef enum logic [2:0] {
    ST_LEN   = 3'b001,
    ST_DATA  = 3'b010,
    ST_WRITE = 3'b100
  } state_t;

endpackage

// File: rtl/uart_loader_byte_packer.sv
// Assembles four bytes LSB-first into a 32-bit word; word_valid strobes with the 4th byte.
module byte_packer
  import uart_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] shreg;

  // The completed word is presented combinationally so the consumer can act on the 4th byte.
  assign word       = {byte_data, shreg[31:8]};
  assign word_valid = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (byte_valid) begin
      shreg    <= word;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Program-image loader: parses a word-count header plus little-endian words from the UART
// byte stream and writes them to memory through a valid/ready port.
module uart_loader
  import uart_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           MAX_WORDS      = 1024,
  parameter int unsigned           TIMEOUT_CYCLES = 65536
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [7:0]            S_axis_tdata,
  input  logic                  S_axis_tvalid,
  output logic                  S_axis_tready,
  output logic [ADDR_WIDTH-1:0] Mem_addr,
  output logic [31:0]           Mem_wdata,
  output logic                  Mem_we,
  input  logic                  Mem_ready,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_next;
  logic             ready_en;
  logic             accept, expire;
  logic [31:0]      word;
  logic             word_valid;
  logic [1:0]       byte_cnt;
  logic [IDX_W-1:0] word_idx, word_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             done_set, err_set, load_n, load_word, idx_inc, pack_clear;

  // tready stays low for the first cycle out of reset and while a write is outstanding.
  assign S_axis_tready = ready_en && (state != ST_WRITE);
  assign accept        = S_axis_tvalid && S_axis_tready;
  assign Busy          = (state != ST_LEN) || (byte_cnt != 2'd0);
  assign expire        = Busy && (state != ST_WRITE) && !accept &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  byte_packer u_packer (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .clear      (pack_clear),
    .byte_valid (accept),
    .byte_data  (S_axis_tdata),
    .byte_cnt   (byte_cnt),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    err_set    = 1'b0;
    load_n     = 1'b0;
    load_word  = 1'b0;
    idx_inc    = 1'b0;
    pack_clear = 1'b0;
    case (state)
      ST_LEN: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            done_set = 1'b1;
          end else if (word > 32'(MAX_WORDS)) begin
            err_set = 1'b1;
          end else begin
            load_n     = 1'b1;
            state_next = ST_DATA;
          end
        end else if (expire) begin
          err_set    = 1'b1;
          pack_clear = 1'b1;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          load_word  = 1'b1;
          state_next = ST_WRITE;
        end else if (expire) begin
          err_set    = 1'b1;
          pack_clear = 1'b1;
          state_next = ST_LEN;
        end
      end
      ST_WRITE: begin
        if (Mem_ready) begin
          idx_inc = 1'b1;
          if ((word_idx + IDX_W'(1)) == word_cnt) begin
            done_set   = 1'b1;
            state_next = ST_LEN;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      default: state_next = ST_LEN;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_LEN;
      ready_en  <= 1'b0;
      word_idx  <= '0;
      word_cnt  <= '0;
      Mem_we    <= 1'b0;
      Mem_addr  <= '0;
      Mem_wdata <= 32'd0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      Done     <= done_set;
      Error    <= err_set;
      if (load_n) begin
        word_cnt <= word[IDX_W-1:0];
        word_idx <= '0;
      end else if (idx_inc) begin
        word_idx <= word_idx + IDX_W'(1);
      end
      if (load_word) begin
        Mem_we    <= 1'b1;
        Mem_addr  <= BASE_ADDR + ADDR_WIDTH'({word_idx, 2'b00});
        Mem_wdata <= word;
      end else if (idx_inc) begin
        Mem_we <= 1'b0;
      end
    end
  end

  // Idle counter runs only while a frame is open and no write is pending.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      to_cnt <= '0;
    end else if (accept || !Busy || expire) begin
      to_cnt <= '0;
    end else if (state != ST_WRITE) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Consumes the byte stream produced by the UART receiver over an AXI-Stream slave port.
- Parses a framed program image: a 4-byte little-endian word-count header, then that many 32-bit little-endian words.
- Writes each assembled word to instruction/data memory through a simple valid/ready write port. Sits between uart_rx and the memory arbiter of the RISC core.
- Reports completion and framing errors with single-cycle pulses.

Parameters:
- ADDR_WIDTH, 32, width of Mem_addr (byte address).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 1024, largest accepted word count; larger headers are rejected.
- TIMEOUT_CYCLES, 65536, idle Clk cycles allowed between bytes inside a frame before abort.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous, active-low reset
- S_axis_tdata  in  8  received byte
- S_axis_tvalid  in  1  byte valid
- S_axis_tready  out  1  loader can accept a byte
- Mem_addr  out  ADDR_WIDTH  write byte address, word aligned
- Mem_wdata  out  32  write data
- Mem_we  out  1  write request; held until accepted
- Mem_ready  in  1  memory accepts the write when Mem_we & Mem_ready
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse: frame fully written
- Error  out  1  one-cycle pulse: oversize header or timeout

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = ST_LEN; byte_cnt = 0; word_idx = 0; timeout counter = 0.
  - All outputs 0, except S_axis_tready = 1 after the first clock edge.
- A byte is accepted when S_axis_tvalid & S_axis_tready. Bytes fill a 32-bit shift register LSB-first: byte 0 -> [7:0], byte 3 -> [31:24].
- ST_LEN:
  - tready = 1. Collects 4 header bytes.
  - On the 4th byte, the count N is taken from the fully assembled header.
  - N == 0 -> Done pulse next cycle, stay in ST_LEN.
  - N > MAX_WORDS -> Error pulse next cycle, stay in ST_LEN.
  - Otherwise latch N, set word_idx = 0, go to ST_DATA.
- ST_DATA:
  - tready = 1. Collects 4 bytes.
  - On the 4th byte, load Mem_wdata and Mem_addr = BASE_ADDR + 4*word_idx, then go to ST_WRITE.
- ST_WRITE:
  - tready = 0; Mem_we = 1. Mem_addr and Mem_wdata are stable until accepted.
  - On Mem_ready: word_idx += 1. If word_idx+1 == N, go to ST_LEN with a Done pulse the next cycle; else go to ST_DATA.
- Mem_we is registered: it rises the cycle after the 4th data byte is accepted and falls the cycle after acceptance.
- Busy = 1 whenever state != ST_LEN or byte_cnt != 0.
- Timeout:
  - The counter clears on every accepted byte and whenever Busy = 0; it is frozen in ST_WRITE.
  - It increments otherwise (ST_LEN with byte_cnt != 0, ST_DATA).
  - Reaching TIMEOUT_CYCLES-1 -> Error pulse; state = ST_LEN, byte_cnt = 0; any partial word is discarded. Words already written stay in memory.
- Simultaneous events:
  - Byte acceptance on the expiry cycle: the byte wins, the counter clears, no Error.
  - Done and Error never pulse together.
- Reset mid-frame: aborts immediately; Mem_we drops asynchronously; no Done.
- word_idx width is $clog2(MAX_WORDS+1); address arithmetic is ADDR_WIDTH wide, wrap ignored.
- State encoding is one-hot, three states: ST_LEN, ST_DATA, ST_WRITE.

Decomposition:
- Package uart_pkg:
  - State enum.
  - FRAME_HDR_BYTES = 4 and WORD_BYTES = 4.
  - Shared with uart_tx/uart_rx for the common baud/oversample constant.
- Sub-module byte_packer: 4-byte LSB-first assembler with byte_cnt, a word_valid strobe and a clear input. Reused by ST_LEN and ST_DATA.
- The timeout counter stays inline.

Test Plan:
1. Header 02 00 00 00 followed by bytes 78 56 34 12, EF BE AD DE, with Mem_ready tied high -> writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, then a Done pulse. Busy falls with Done.
2. Same frame with Mem_ready low for 10 cycles on each write -> S_axis_tready = 0 throughout each stall, Mem_addr/Mem_wdata stable, writes identical, no Error.
3. Header 01 04 00 00 (N = 1025 > MAX_WORDS) -> Error pulse, no Mem_we. A following valid 1-word frame loads correctly.
4. Header 00 00 00 00 -> Done pulse 1 cycle after the 4th byte, no Mem_we.
5. TIMEOUT_CYCLES = 16; send header 01 00 00 00 and 2 data bytes, then idle 16 cycles -> Error pulse, no Mem_we, Busy = 0. Also check a byte arriving exactly on the expiry cycle gives no Error.
6. Assert Rst_n low mid-ST_WRITE -> Mem_we drops immediately, all outputs 0. After release, a new frame loads from BASE_ADDR.
